// File: rtl/wave_capture_mc.sv
// Multi-channel zero-crossing capture engine writing frames into a ping-pong waveform RAM.
// Latency: first RAM write one cycle after the storing strobe, then one channel per cycle.
// No backpressure: strobes arriving during a write burst are dropped and flagged on sticky overrun.
module wave_capture_mc #(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 1024,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW          = 1 + CH_W + DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] new_sample_in,
    input  logic [1:0]                 trig_mode,
    input  logic [CH_W-1:0]            trig_ch,
    input  logic                       wave_display_idle,
    output logic [AW-1:0]              write_address,
    output logic                       write_enable,
    output logic [OUT_W-1:0]           write_sample,
    output logic                       read_index,
    output logic                       capturing,
    output logic                       overrun
);
    localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, trig_sel, burst_ch, next_ch;
    logic [DEPTH_LOG2-1:0] sample_index, burst_index, store_idx;
    logic [TO_W-1:0]       timeout_cnt;
    logic                  prev_msb, cur_msb, last_write;
    logic                  trigger, store, drop, flip;
    logic [OUT_W-1:0]      cur_off [NUM_CH];
    logic [OUT_W-1:0]      lat_off [NUM_CH];
    logic                  unused_sample_lsbs;

    // Two's complement to offset binary is just an MSB flip of the kept top bits.
    function automatic logic [OUT_W-1:0] to_offset(input logic [OUT_W-1:0] t);
        return t ^ (OUT_W'(1) << (OUT_W - 1));
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cur_off[c] = to_offset(new_sample_in[c*SAMPLE_W + SAMPLE_W - 1 -: OUT_W]);
        end
    end

    // Only the top OUT_W bits of each sample are stored.
    assign unused_sample_lsbs = ^new_sample_in;

    // The trigger channel follows trig_ch only while armed; elsewhere the armed choice is held.
    assign trig_sel   = (state_q != S_ARMED) ? ch_q :
                        (int'(trig_ch) < NUM_CH) ? trig_ch : '0;
    assign cur_msb    = ~cur_off[trig_sel][OUT_W-1];
    assign last_write = write_enable && (burst_ch == CH_W'(NUM_CH - 1));
    assign next_ch    = burst_ch + 1'b1;
    assign store_idx  = (state_q == S_ARMED) ? '0 : sample_index;
    assign capturing  = (state_q == S_ACTIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trigger = 1'b0;
        store   = 1'b0;
        drop    = 1'b0;
        flip    = 1'b0;
        case (state_q)
            S_ARMED: begin
                case (trig_mode)
                    2'd0:    trigger = prev_msb & ~cur_msb;
                    2'd1:    trigger = ~prev_msb & cur_msb;
                    2'd2:    trigger = 1'b1;
                    default: trigger = (prev_msb & ~cur_msb) |
                                       (timeout_cnt == TO_W'(AUTO_TIMEOUT - 1));
                endcase
                trigger = trigger & new_sample_ready;
                if (trigger) begin
                    store   = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (new_sample_ready) begin
                    if (write_enable) begin
                        drop = 1'b1;
                    end else begin
                        store = 1'b1;
                    end
                end
                if (last_write && (burst_index == '1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wave_display_idle) begin
                    flip    = 1'b1;
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q          <= '0;
            prev_msb      <= 1'b0;
            timeout_cnt   <= '0;
            sample_index  <= '0;
            burst_index   <= '0;
            burst_ch      <= '0;
            read_index    <= 1'b0;
            overrun       <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                lat_off[c] <= '0;
            end
        end else begin
            if (state_q == S_ARMED) begin
                ch_q <= trig_sel;
            end
            if (new_sample_ready) begin
                prev_msb <= cur_msb;
            end
            if (state_q != S_ARMED) begin
                timeout_cnt <= '0;
            end else if (new_sample_ready && !trigger) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (flip) begin
                read_index <= ~read_index;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            // Channel 0 goes out straight from the input; the rest come from the latch.
            if (store) begin
                lat_off       <= cur_off;
                sample_index  <= store_idx + 1'b1;
                burst_index   <= store_idx;
                burst_ch      <= '0;
                write_enable  <= 1'b1;
                write_address <= {~read_index, CH_W'(0), store_idx};
                write_sample  <= cur_off[0];
            end else if (write_enable && !last_write) begin
                burst_ch      <= next_ch;
                write_address <= {~read_index, next_ch, burst_index};
                write_sample  <= lat_off[next_ch];
            end else begin
                write_enable  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wave_capture_mc.sv
// Directed/random bench for wave_capture_mc with a slot-based reference model and write scoreboard.
module tb_wave_capture_mc;
    localparam int NUM_CH       = 2;
    localparam int SAMPLE_W     = 16;
    localparam int OUT_W        = 8;
    localparam int DEPTH_LOG2   = 3;
    localparam int AUTO_TIMEOUT = 4;
    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam int CH_W         = 1;
    localparam int AW           = 1 + CH_W + DEPTH_LOG2;
    localparam int HALF_SPAN    = 1 << (CH_W + DEPTH_LOG2);
    localparam int SCALE        = 1 << (SAMPLE_W - OUT_W);

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       new_sample_ready = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0] new_sample_in = '0;
    logic [1:0]                 trig_mode = 2'd0;
    logic [CH_W-1:0]            trig_ch = '0;
    logic                       wave_display_idle = 1'b1;
    logic [AW-1:0]              write_address;
    logic                       write_enable;
    logic [OUT_W-1:0]           write_sample;
    logic                       read_index;
    logic                       capturing;
    logic                       overrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wave_capture_mc #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
        .DEPTH_LOG2(DEPTH_LOG2), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .new_sample_ready(new_sample_ready), .new_sample_in(new_sample_in),
        .trig_mode(trig_mode), .trig_ch(trig_ch),
        .wave_display_idle(wave_display_idle),
        .write_address(write_address), .write_enable(write_enable),
        .write_sample(write_sample), .read_index(read_index),
        .capturing(capturing), .overrun(overrun)
    );

    typedef struct {
        int addr;
        int data;
        int slot;
    } wr_t;

    wr_t exp_q[$];
    int  slot_no = 0;
    // Model phase: 0 waiting for trigger, 1 filling a frame, 2 waiting for the display.
    int  m_phase, m_half, m_cnt, m_idx, m_ovr, m_ch, m_last, m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sval(input logic [SAMPLE_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'($urandom());
    endfunction

    task automatic model_clear();
        m_phase = 0; m_half = 0; m_cnt = 0; m_idx = 0;
        m_ovr = 0; m_ch = 0; m_last = -1000; m_prev = 0;
        exp_q.delete();
    endtask

    task automatic model_store(input int idx, input int k);
        for (int c = 0; c < NUM_CH; c++) begin
            wr_t w;
            w.addr = (1 - m_half) * HALF_SPAN + c * DEPTH + idx;
            w.data = (sval(new_sample_in[c*SAMPLE_W +: SAMPLE_W]) + 32768) / SCALE;
            w.slot = k + 1 + c;
            exp_q.push_back(w);
        end
        m_last = k;
    endtask

    // Slot k is the interval ending at the (k+1)-th rising edge; inputs held over it are evaluated here.
    always @(posedge clk) begin : ref_model
        int k, cur;
        bit was_wait, trig;
        k = slot_no;
        slot_no++;
        if (!reset) begin
            model_clear();
        end else begin
            was_wait = (m_phase == 2);
            if (m_phase == 0) m_ch = (int'(trig_ch) < NUM_CH) ? int'(trig_ch) : 0;
            if (new_sample_ready) begin
                cur = sval(new_sample_in[m_ch*SAMPLE_W +: SAMPLE_W]);
                if (m_phase == 0) begin
                    case (trig_mode)
                        2'd0:    trig = (m_prev < 0) && (cur >= 0);
                        2'd1:    trig = (m_prev >= 0) && (cur < 0);
                        2'd2:    trig = 1'b1;
                        default: trig = ((m_prev < 0) && (cur >= 0)) || (m_cnt == AUTO_TIMEOUT - 1);
                    endcase
                    if (trig) begin
                        model_store(0, k);
                        m_idx = 1;
                        m_phase = 1;
                    end else begin
                        m_cnt++;
                    end
                end else if (m_phase == 1) begin
                    if (k <= m_last + NUM_CH) begin
                        m_ovr = 1;
                    end else begin
                        model_store(m_idx, k);
                        m_idx++;
                    end
                end
                m_prev = cur;
            end
            if (was_wait && wave_display_idle) begin
                m_half = 1 - m_half;
                m_phase = 0;
                m_cnt = 0;
            end
            if (m_phase == 1 && m_idx == DEPTH && k + 1 >= m_last + NUM_CH + 1) m_phase = 2;
        end
    end

    always @(negedge clk) begin : monitor
        wr_t w;
        if (write_enable) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr %0h data %0h, expected no write",
                       write_address, write_sample);
            end
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(write_address), w.addr);
                chk("wr_data", 32'(write_sample), w.data);
                chk("wr_slot", slot_no, w.slot);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] s0, input logic [15:0] s1, input int gap);
        new_sample_in = {s1, s0};
        new_sample_ready = 1'b1;
        tick(1);
        new_sample_ready = 1'b0;
        tick(gap);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_we"}, 32'(write_enable), 0);
        chk({pfx, "_addr"}, 32'(write_address), 0);
        chk({pfx, "_data"}, 32'(write_sample), 0);
        chk({pfx, "_ridx"}, 32'(read_index), 0);
        chk({pfx, "_capt"}, 32'(capturing), 0);
        chk({pfx, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin : stimulus
        #1 reset = 1'b0;
        #1 chk_all_zero("rst");
        tick(2);
        reset = 1'b1;
        tick(2);

        // Rising trigger on ch0, display kept busy afterwards.
        trig_mode = 2'd0; trig_ch = 1'b0; wave_display_idle = 1'b0;
        strobe(16'hFFFB, rnd16(), 3);
        strobe(16'hFFFF, rnd16(), 3);
        chk("t1_armed", 32'(capturing), 0);
        new_sample_in = {rnd16(), 16'h0003};
        new_sample_ready = 1'b1;
        tick(1);
        new_sample_ready = 1'b0;
        chk("t1_we", 32'(write_enable), 1);
        chk("t1_addr0", 32'(write_address), 32'h10);
        chk("t1_data0", 32'(write_sample), 32'h80);
        chk("t1_capt", 32'(capturing), 1);
        tick(3);
        for (int i = 0; i < 7; i++) strobe(rnd16(), rnd16(), 3);
        chk("t1_wait_capt", 32'(capturing), 0);
        strobe(16'h8000, rnd16(), 3);
        strobe(16'h0100, rnd16(), 3);
        tick(42);
        chk("t1_hold_ridx", 32'(read_index), 0);
        chk("t1_hold_we", 32'(write_enable), 0);
        chk("t1_pending", exp_q.size(), 0);
        wave_display_idle = 1'b1;
        tick(1);
        chk("t1_flip_ridx", 32'(read_index), 1);

        // Falling trigger on ch1 while ch0 crosses too; writes land in half 0.
        trig_mode = 2'd1; trig_ch = 1'b1;
        strobe(16'h8000, 16'h0100, 3);
        chk("t2_armed", 32'(capturing), 0);
        new_sample_in = {16'hFF00, 16'h8000};
        new_sample_ready = 1'b1;
        tick(1);
        new_sample_ready = 1'b0;
        chk("t2_addr0", 32'(write_address), 32'h00);
        chk("t2_data0", 32'(write_sample), 32'h00);
        tick(1);
        chk("t2_addr1", 32'(write_address), 32'h08);
        chk("t2_data1", 32'(write_sample), 32'h7F);
        tick(2);
        for (int i = 0; i < 7; i++) strobe(rnd16(), rnd16(), 2);
        tick(5);
        chk("t2_ridx", 32'(read_index), 0);
        chk("t2_capt", 32'(capturing), 0);

        // Free-run with a too-close strobe, then random spacing until the frame is done.
        trig_mode = 2'd2; trig_ch = 1'b0; wave_display_idle = 1'b0;
        strobe(rnd16(), rnd16(), 1);
        strobe(rnd16(), rnd16(), 2);
        chk("t3_ovr", 32'(overrun), 1);
        for (int i = 0; i < 60 && m_phase == 1; i++) strobe(rnd16(), rnd16(), $urandom_range(0, 3));
        tick(4);
        chk("t3_capt", 32'(capturing), 0);
        chk("t3_ovr_sticky", 32'(overrun), 1);
        chk("t3_ovr_model", 32'(overrun), m_ovr);
        strobe(16'h1000, 16'h1000, 2);

        // Auto mode: constant positive input never crosses, the timeout forces the 4th sample.
        trig_mode = 2'd3; trig_ch = 1'b0; wave_display_idle = 1'b1;
        tick(1);
        chk("t4_ridx", 32'(read_index), 1);
        for (int i = 0; i < 3; i++) strobe(16'h1000, 16'h1000, 3);
        chk("t4_no_trig", 32'(capturing), 0);
        new_sample_in = {16'h1000, 16'h1000};
        new_sample_ready = 1'b1;
        tick(1);
        new_sample_ready = 1'b0;
        chk("t4_we", 32'(write_enable), 1);
        chk("t4_data0", 32'(write_sample), 32'h90);
        chk("t4_addr0", 32'(write_address), 32'h00);
        chk("t4_capt", 32'(capturing), 1);

        // Reset during the second write of the burst.
        tick(1);
        chk("t5_we_pre", 32'(write_enable), 1);
        chk("t5_addr_pre", 32'(write_address), 32'h08);
        #2 reset = 1'b0;
        exp_q.delete();
        #1 chk_all_zero("t5_rst");
        tick(2);
        reset = 1'b1;
        trig_mode = 2'd2;
        tick(1);
        new_sample_in = {rnd16(), 16'h7FFF};
        new_sample_ready = 1'b1;
        tick(1);
        new_sample_ready = 1'b0;
        chk("t5_addr0", 32'(write_address), 32'h10);
        chk("t5_data0", 32'(write_sample), 32'hFF);
        tick(2);
        for (int i = 0; i < 7; i++) strobe(rnd16(), rnd16(), 2);
        tick(6);
        chk("t5_ridx", 32'(read_index), 1);
        chk("t5_capt", 32'(capturing), 0);
        chk("t5_ovr", 32'(overrun), 0);
        chk("final_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
